// File: rtl/if_prefetch.sv
// Instruction fetch unit: issues one word request at a time and buffers
// returned instructions with their PC in a DEPTH-entry queue for IF/ID.
module if_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc4,
  input  logic        out_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_target
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  localparam logic [1:0] S_REQ   = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      pend_pc_q, pend_pc_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [31:0]      fifo_instr_q [DEPTH];
  logic [31:0]      fifo_instr_d [DEPTH];
  logic [31:0]      fifo_pc_q    [DEPTH];
  logic [31:0]      fifo_pc_d    [DEPTH];

  logic pop;
  logic push;
  logic xfer;
  logic room;

  always_comb begin
    out_valid = (count_q != '0);
    out_instr = fifo_instr_q[rd_ptr_q];
    out_pc4   = fifo_pc_q[rd_ptr_q] + 32'd4;
    pop       = out_valid & out_ready;
    // A slot is guaranteed only if the queue is not full after this cycle's pop
    room      = (count_q < DEPTH_C) | pop;
    imem_req  = (state_q == S_REQ) & room;
    imem_addr = fetch_pc_q;
    xfer      = imem_req & imem_ready;
    push      = (state_q == S_WAIT) & imem_rvalid & ~redirect;
  end

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pend_pc_d    = pend_pc_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    fifo_instr_d = fifo_instr_q;
    fifo_pc_d    = fifo_pc_q;

    case (state_q)
      S_REQ: begin
        if (xfer) begin
          pend_pc_d  = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = S_WAIT;
        end
      end
      S_WAIT:  if (imem_rvalid) state_d = S_REQ;
      S_DRAIN: if (imem_rvalid) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase

    if (push) begin
      fifo_instr_d[wr_ptr_q] = imem_rdata;
      fifo_pc_d[wr_ptr_q]    = pend_pc_q;
      wr_ptr_d               = wr_ptr_q + PTR_ONE;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push && !pop) count_d = count_q + CNT_ONE;
    if (pop && !push) count_d = count_q - CNT_ONE;

    // DRAIN is kept only while a response is still owed; one arriving this
    // cycle is the stale one, so fetch can restart immediately.
    if (redirect) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      fetch_pc_d = redirect_target & 32'hFFFF_FFFC;
      if (((state_q == S_WAIT) || (state_q == S_DRAIN)) && !imem_rvalid)
        state_d = S_DRAIN;
      else if ((state_q == S_REQ) && xfer)
        state_d = S_DRAIN;
      else
        state_d = S_REQ;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_REQ;
      fetch_pc_q <= RESET_PC;
      pend_pc_q  <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    fifo_instr_q <= fifo_instr_d;
    fifo_pc_q    <= fifo_pc_d;
  end

endmodule
